multicycle_sequencer: RTL and testbench

- Main state machine for the multi-cycle RV32I core variant; one unified instruction/data memory and one ALU, shared across cycles.
- Reads opcode/funct3 from the instruction register and issues per-state datapath strobes and mux selects.
- Runs the memory request/ready handshake, raises a sticky halt on illegal opcodes and counts retired instructions.
- ALU function decode is done outside this block, by the ALU decoder, from alu_op.

---
 rtl/rv_ctrl_pkg.sv | 81 ++++++++
 rtl/multicycle_sequencer.sv | 242 ++++++++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rv_ctrl_pkg
// Shared definitions for the multi-cycle RV32I control path: the main
// sequencer state enum, the base opcodes the sequencer recognises, and the
// datapath mux / ALU-op / immediate-format encodings it drives.
// No ports (package).
// ---------------------------------------------------------------------------
package rv_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_RESET    = 4'd0,
      ST_FETCH    = 4'd1,
      ST_DECODE   = 4'd2,
      ST_MEMADR   = 4'd3,
      ST_MEMREAD  = 4'd4,
      ST_MEMWB    = 4'd5,
      ST_MEMWRITE = 4'd6,
      ST_EXECR    = 4'd7,
      ST_EXECI    = 4'd8,
      ST_ALUWB    = 4'd9,
      ST_BRANCH   = 4'd10,
      ST_JALR     = 4'd11,
      ST_JAL      = 4'd12,
      ST_LUI      = 4'd13,
      ST_AUIPC    = 4'd14,
      ST_TRAP     = 4'd15
   } state_t;

   // Base opcodes (IR[6:0])
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   // ALU A operand select
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   // ALU B operand select
   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // ALU operation class, expanded by the ALU decoder
   localparam logic [1:0] ALUOP_ADD     = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH  = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT   = 2'b10;
   localparam logic [1:0] ALUOP_PASSIMM = 2'b11;

   // Result mux select
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_MEMDATA   = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   // Immediate formats
   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   // Immediate format implied by an opcode; anything unlisted uses I-type.
   function automatic logic [2:0] imm_src_of(input logic [6:0] op);
      logic [2:0] fmt;
      case (op)
         OP_STORE:         fmt = IMM_S;
         OP_BRANCH:        fmt = IMM_B;
         OP_JAL:           fmt = IMM_J;
         OP_LUI, OP_AUIPC: fmt = IMM_U;
         default:          fmt = IMM_I;
      endcase
      return fmt;
   endfunction

endpackage

// File: rtl/multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// multicycle_sequencer
// Main control FSM of the multi-cycle RV32I core (shared memory, shared ALU).
// Steps each instruction through fetch / decode / execute / memory /
// write-back states, issuing datapath strobes and mux selects, running the
// memory request/ready handshake, trapping on illegal opcodes and counting
// retired instructions.
//
// Ports:
//   clk, rst_n        clock (rising edge), synchronous active-low reset
//   opcode, funct3    IR[6:0], IR[14:12]
//   branch_taken      branch comparator result, used in BRANCH
//   mem_ready         memory completes the current request this cycle
//   mem_req, mem_we   memory request and write qualifier
//   adr_src           memory address select (0 PC, 1 ALUOut)
//   ir_write          load IR and OldPC
//   pc_write          load PC from the result mux
//   reg_write         register file write enable
//   alu_src_a/b       ALU operand selects
//   alu_op            ALU operation class for the ALU decoder
//   result_src        result mux select
//   imm_src           immediate format
//   halted            sticky illegal-opcode flag
//   retire            one-cycle pulse on the last cycle of an instruction
//   instret           retired-instruction count (wraps)
// ---------------------------------------------------------------------------
module multicycle_sequencer
   import rv_ctrl_pkg::*;
#(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [6:0]           opcode,
   input  logic [2:0]           funct3,
   input  logic                 branch_taken,
   input  logic                 mem_ready,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic                 adr_src,
   output logic                 ir_write,
   output logic                 pc_write,
   output logic                 reg_write,
   output logic [1:0]           alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic [1:0]           alu_op,
   output logic [1:0]           result_src,
   output logic [2:0]           imm_src,
   output logic                 halted,
   output logic                 retire,
   output logic [CNT_WIDTH-1:0] instret
);

   state_t state_r;
   state_t next_state_s;

   // funct3 is consumed by the ALU decoder and branch comparator, not here.
   logic unused_funct3_s;
   assign unused_funct3_s = ^funct3;

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_RESET;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Retired-instruction counter; advances on the edge that ends an instruction.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         instret <= '0;
      end else if (retire) begin
         instret <= instret + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         instret <= instret;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_RESET: next_state_s = ST_FETCH;
         ST_FETCH: begin
            if (mem_ready) begin
               next_state_s = ST_DECODE;
            end else begin
               next_state_s = ST_FETCH;
            end
         end
         ST_DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: next_state_s = ST_MEMADR;
               OP_RTYPE:          next_state_s = ST_EXECR;
               OP_ITYPE:          next_state_s = ST_EXECI;
               OP_BRANCH:         next_state_s = ST_BRANCH;
               OP_JAL:            next_state_s = ST_JAL;
               OP_JALR:           next_state_s = ST_JALR;
               OP_LUI:            next_state_s = ST_LUI;
               OP_AUIPC:          next_state_s = ST_AUIPC;
               default:           next_state_s = ST_TRAP;
            endcase
         end
         ST_MEMADR: begin
            if (opcode == OP_LOAD) begin
               next_state_s = ST_MEMREAD;
            end else begin
               next_state_s = ST_MEMWRITE;
            end
         end
         ST_MEMREAD: begin
            if (mem_ready) begin
               next_state_s = ST_MEMWB;
            end else begin
               next_state_s = ST_MEMREAD;
            end
         end
         ST_MEMWRITE: begin
            if (mem_ready) begin
               next_state_s = ST_FETCH;
            end else begin
               next_state_s = ST_MEMWRITE;
            end
         end
         ST_MEMWB, ST_ALUWB, ST_BRANCH: next_state_s = ST_FETCH;
         ST_EXECR, ST_EXECI:            next_state_s = ST_ALUWB;
         // JALR computes rs1+imm into ALUOut, then shares JAL's PC update.
         ST_JALR:                       next_state_s = ST_JAL;
         ST_JAL, ST_LUI, ST_AUIPC:      next_state_s = ST_ALUWB;
         ST_TRAP:                       next_state_s = ST_TRAP;
         default:                       next_state_s = ST_RESET;
      endcase
   end

   // Output decode: Moore per state, plus the mem_ready / branch_taken gates.
   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RS2;
      alu_op     = ALUOP_ADD;
      result_src = RES_ALUOUT;
      imm_src    = IMM_I;
      halted     = 1'b0;
      retire     = 1'b0;
      case (state_r)
         ST_RESET: begin
            halted = 1'b0;
         end
         ST_FETCH: begin
            mem_req    = 1'b1;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALURESULT;
            ir_write   = mem_ready;
            pc_write   = mem_ready;
         end
         ST_DECODE: begin
            // Precompute OldPC + imm as the branch/JAL target.
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            imm_src   = imm_src_of(opcode);
         end
         ST_MEMADR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            imm_src   = imm_src_of(opcode);
         end
         ST_MEMREAD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
         end
         ST_MEMWB: begin
            result_src = RES_MEMDATA;
            reg_write  = 1'b1;
            retire     = 1'b1;
         end
         ST_MEMWRITE: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            adr_src = 1'b1;
            retire  = mem_ready;
         end
         ST_EXECR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_RS2;
            alu_op    = ALUOP_FUNCT;
         end
         ST_EXECI: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_FUNCT;
         end
         ST_ALUWB: begin
            result_src = RES_ALUOUT;
            reg_write  = 1'b1;
            retire     = 1'b1;
         end
         ST_BRANCH: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_RS2;
            alu_op     = ALUOP_BRANCH;
            result_src = RES_ALUOUT;
            pc_write   = branch_taken;
            retire     = 1'b1;
         end
         ST_JALR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
         end
         ST_JAL: begin
            // PC <= ALUOut (target) while the ALU forms OldPC + 4 for rd.
            result_src = RES_ALUOUT;
            pc_write   = 1'b1;
            alu_src_a  = SRCA_OLDPC;
            alu_src_b  = SRCB_FOUR;
         end
         ST_LUI: begin
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_PASSIMM;
            imm_src   = IMM_U;
         end
         ST_AUIPC: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            imm_src   = IMM_U;
         end
         ST_TRAP: begin
            halted = 1'b1;
         end
         default: begin
            halted = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// tb_multicycle_sequencer
// Self-checking bench. The reference is an instruction-level model: on
// decode it expands the opcode into the list of steps that instruction
// takes, walks that list (stalling on memory steps while mem_ready is low),
// and marks the final step of the list as the retiring one. Directed
// sequences pin the model with literal expectations, then a randomized run
// is compared every cycle.
// ---------------------------------------------------------------------------
module tb_multicycle_sequencer;

   localparam int CW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [6:0]    opcode;
   logic [2:0]    funct3;
   logic          branch_taken;
   logic          mem_ready;
   logic          mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
   logic [1:0]    alu_src_a, alu_src_b, alu_op, result_src;
   logic [2:0]    imm_src;
   logic          halted, retire;
   logic [CW-1:0] instret;

   multicycle_sequencer #(.CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
      .branch_taken(branch_taken), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src),
      .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .result_src(result_src), .imm_src(imm_src), .halted(halted),
      .retire(retire), .instret(instret)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
      logic [1:0] a, b, op, rs;
      logic [2:0] imm;
      logic       halted, retire;
   } vec_t;

   // Instruction steps
   localparam int U_RESET = 0,  U_FETCH = 1,  U_DECODE = 2,  U_MEMADR = 3;
   localparam int U_MEMREAD = 4, U_MEMWB = 5, U_MEMWRITE = 6, U_EXECR = 7;
   localparam int U_EXECI = 8,  U_ALUWB = 9,  U_BRANCH = 10, U_JALR = 11;
   localparam int U_JAL = 12,   U_LUI = 13,   U_AUIPC = 14,  U_TRAP = 15;

   int            m_uop;
   int            plan[$];
   logic [CW-1:0] m_instret;
   bit            m_valid = 1'b0;
   int            n_cmp = 0;
   int            n_bad = 0;

   logic [6:0] op_tab [9];
   initial begin
      op_tab[0] = 7'b0000011; op_tab[1] = 7'b0100011; op_tab[2] = 7'b0110011;
      op_tab[3] = 7'b0010011; op_tab[4] = 7'b1100011; op_tab[5] = 7'b1101111;
      op_tab[6] = 7'b1100111; op_tab[7] = 7'b0110111; op_tab[8] = 7'b0010111;
   end

   function automatic vec_t dut_vec();
      vec_t v;
      v = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, alu_op, result_src, imm_src, halted, retire};
      return v;
   endfunction

   function automatic logic [2:0] imm_of(input logic [6:0] op);
      if (op == 7'b0100011) return 3'd1;
      if (op == 7'b1100011) return 3'd2;
      if (op == 7'b1101111) return 3'd3;
      if (op == 7'b0110111 || op == 7'b0010111) return 3'd4;
      return 3'd0;
   endfunction

   function automatic bit is_wait(input int u);
      return (u == U_FETCH || u == U_MEMREAD || u == U_MEMWRITE);
   endfunction

   // Expected outputs for the current model step and current inputs.
   function automatic vec_t model_out();
      vec_t e;
      bit   last;
      e = '0;
      case (m_uop)
         U_FETCH:    begin e.mem_req = 1'b1; e.ir_write = mem_ready; e.pc_write = mem_ready;
                           e.b = 2'd2; e.rs = 2'd2; end
         U_DECODE:   begin e.a = 2'd1; e.b = 2'd1; e.imm = imm_of(opcode); end
         U_MEMADR:   begin e.a = 2'd2; e.b = 2'd1; e.imm = imm_of(opcode); end
         U_MEMREAD:  begin e.mem_req = 1'b1; e.adr_src = 1'b1; end
         U_MEMWB:    begin e.rs = 2'd1; e.reg_write = 1'b1; end
         U_MEMWRITE: begin e.mem_req = 1'b1; e.mem_we = 1'b1; e.adr_src = 1'b1; end
         U_EXECR:    begin e.a = 2'd2; e.op = 2'd2; end
         U_EXECI:    begin e.a = 2'd2; e.b = 2'd1; e.op = 2'd2; end
         U_ALUWB:    begin e.reg_write = 1'b1; end
         U_BRANCH:   begin e.a = 2'd2; e.op = 2'd1; e.pc_write = branch_taken; end
         U_JALR:     begin e.a = 2'd2; e.b = 2'd1; end
         U_JAL:      begin e.pc_write = 1'b1; e.a = 2'd1; e.b = 2'd2; end
         U_LUI:      begin e.b = 2'd1; e.op = 2'd3; e.imm = 3'd4; end
         U_AUIPC:    begin e.a = 2'd1; e.b = 2'd1; e.imm = 3'd4; end
         U_TRAP:     begin e.halted = 1'b1; end
         default:    begin e = '0; end
      endcase
      last = (plan.size() == 0) &&
             !(m_uop == U_RESET || m_uop == U_FETCH || m_uop == U_DECODE || m_uop == U_TRAP);
      e.retire = last && (!is_wait(m_uop) || mem_ready);
      return e;
   endfunction

   task automatic build_plan(input logic [6:0] op);
      plan.delete();
      case (op)
         7'b0000011: begin plan.push_back(U_MEMADR); plan.push_back(U_MEMREAD);
                           plan.push_back(U_MEMWB); end
         7'b0100011: begin plan.push_back(U_MEMADR); plan.push_back(U_MEMWRITE); end
         7'b0110011: begin plan.push_back(U_EXECR); plan.push_back(U_ALUWB); end
         7'b0010011: begin plan.push_back(U_EXECI); plan.push_back(U_ALUWB); end
         7'b1100011: plan.push_back(U_BRANCH);
         7'b1101111: begin plan.push_back(U_JAL); plan.push_back(U_ALUWB); end
         7'b1100111: begin plan.push_back(U_JALR); plan.push_back(U_JAL);
                           plan.push_back(U_ALUWB); end
         7'b0110111: begin plan.push_back(U_LUI); plan.push_back(U_ALUWB); end
         7'b0010111: begin plan.push_back(U_AUIPC); plan.push_back(U_ALUWB); end
         default:    plan.push_back(U_TRAP);
      endcase
   endtask

   // Advance the model across one rising edge.
   task automatic model_edge();
      vec_t e;
      if (!rst_n) begin
         m_uop = U_RESET; plan.delete(); m_instret = '0; m_valid = 1'b1;
      end else if (m_valid) begin
         e = model_out();
         if (e.retire) m_instret = m_instret + CW'(1);
         if (m_uop == U_RESET) m_uop = U_FETCH;
         else if (m_uop == U_TRAP) m_uop = U_TRAP;
         else if (m_uop == U_FETCH) begin
            if (mem_ready) m_uop = U_DECODE;
         end else if (m_uop == U_DECODE) begin
            build_plan(opcode);
            m_uop = plan.pop_front();
         end else if (!is_wait(m_uop) || mem_ready) begin
            if (plan.size() == 0) m_uop = U_FETCH;
            else m_uop = plan.pop_front();
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
      end
   endtask

   // One cycle: compare on the falling edge, update the model on the rising
   // edge, then return just after it so new inputs can be driven.
   task automatic tick();
      vec_t e, d;
      @(negedge clk);
      if (m_valid) begin
         e = model_out();
         d = dut_vec();
         n_cmp++;
         if (d !== e) begin
            n_bad++;
            $display("FAIL cycle_outputs step=%0d: got %h expected %h (t=%0t)", m_uop, d, e, $time);
         end
         n_cmp++;
         if (instret !== m_instret) begin
            n_bad++;
            $display("FAIL cycle_instret: got %0d expected %0d (t=%0t)", instret, m_instret, $time);
         end
      end
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   int cyc;

   initial begin
      rst_n = 1'b0; opcode = 7'd0; funct3 = 3'd0; branch_taken = 1'b0; mem_ready = 1'b0;

      // Reset held for two edges
      tick(); tick(); settle();
      chk("reset_outputs", {13'd0, dut_vec()}, 32'd0);
      chk("reset_instret", instret, 32'd0);
      rst_n = 1'b1;
      tick(); settle();
      chk("release_mem_req", 32'(mem_req), 32'd1);

      // addi with three not-ready cycles in FETCH
      opcode = 7'b0010011; mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("addi_wait_mem_req", 32'(mem_req), 32'd1);
         chk("addi_wait_ir_write", 32'(ir_write), 32'd0);
         tick();
      end
      mem_ready = 1'b1; settle();
      chk("addi_ir_write", 32'(ir_write), 32'd1);
      tick(); tick(); settle();
      chk("execi_alu_src_b", 32'(alu_src_b), 32'd1);
      chk("execi_alu_op", 32'(alu_op), 32'd2);
      tick(); settle();
      chk("addi_reg_write", 32'(reg_write), 32'd1);
      chk("addi_retire", 32'(retire), 32'd1);
      tick(); settle();
      chk("addi_instret", instret, 32'd1);

      // lw with two wait cycles in MEMREAD: 7 cycles FETCH to FETCH
      opcode = 7'b0000011; cyc = 0;
      do begin
         mem_ready = !(cyc == 3 || cyc == 4);
         settle();
         if (cyc == 3 || cyc == 4) chk("lw_adr_src", 32'(adr_src), 32'd1);
         if (cyc == 6) chk("lw_result_src", 32'(result_src), 32'd1);
         tick();
         cyc++;
      end while (m_uop != U_FETCH && cyc < 20);
      chk("lw_cycles", cyc, 32'd7);
      chk("lw_instret", instret, 32'd2);

      // beq taken then not taken
      mem_ready = 1'b1; opcode = 7'b1100011;
      branch_taken = 1'b1;
      tick(); tick(); settle();
      chk("beq_taken_pc_write", 32'(pc_write), 32'd1);
      chk("beq_taken_retire", 32'(retire), 32'd1);
      tick();
      branch_taken = 1'b0;
      tick(); tick(); settle();
      chk("beq_nt_pc_write", 32'(pc_write), 32'd0);
      chk("beq_nt_retire", 32'(retire), 32'd1);
      tick(); settle();
      chk("beq_instret", instret, 32'd4);

      // jalr: DECODE, JALR, JAL, ALUWB
      opcode = 7'b1100111;
      tick(); tick(); tick(); settle();
      chk("jal_pc_write", 32'(pc_write), 32'd1);
      chk("jal_result_src", 32'(result_src), 32'd0);
      tick(); settle();
      chk("jalr_reg_write", 32'(reg_write), 32'd1);
      tick(); settle();
      chk("jalr_instret", instret, 32'd5);

      // Illegal opcode traps until reset
      opcode = 7'b1111111;
      tick(); tick();
      for (int i = 0; i < 10; i++) begin
         settle();
         chk("trap_halted", 32'(halted), 32'd1);
         chk("trap_retire", 32'(retire), 32'd0);
         tick();
      end
      rst_n = 1'b0;
      tick(); settle();
      chk("trap_cleared", 32'(halted), 32'd0);
      rst_n = 1'b1;
      tick();

      // Reset in the middle of a store handshake
      opcode = 7'b0100011; mem_ready = 1'b1;
      tick(); tick();
      mem_ready = 1'b0;
      tick(); settle();
      chk("sw_mem_we", 32'(mem_we), 32'd1);
      chk("sw_wait_retire", 32'(retire), 32'd0);
      rst_n = 1'b0;
      tick(); settle();
      chk("sw_rst_mem_req", 32'(mem_req), 32'd0);
      chk("sw_rst_mem_we", 32'(mem_we), 32'd0);
      chk("sw_rst_instret", instret, 32'd0);
      rst_n = 1'b1;
      tick();

      // Randomized run against the model
      for (int i = 0; i < 4000; i++) begin
         if (m_uop == U_FETCH || m_uop == U_RESET) begin
            if ($urandom_range(19, 0) == 0) opcode = 7'($urandom_range(127, 0));
            else opcode = op_tab[$urandom_range(8, 0)];
         end
         mem_ready    = ($urandom_range(3, 0) != 0);
         branch_taken = 1'($urandom_range(1, 0));
         funct3       = 3'($urandom_range(7, 0));
         rst_n = !((m_uop == U_TRAP && $urandom_range(7, 0) == 0) ||
                   $urandom_range(299, 0) == 0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
